// File: rtl/ser_to_par8.sv
// ser_to_par8: serial-to-parallel deserializer, WIDTH bits per frame, valid/ready output.
// Latency: data_valid rises on the cycle after the sampling edge of the last bit (or parity bit).
// Backpressure: the word is held in HOLD until out_ready; a start seen while held and not
//   accepted is dropped and raises the sticky overrun flag.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   start                   frame-start pulse (also restarts a frame in progress)
//   ser_in, bit_valid       serial bit and its qualifier
//   out_ready               consumer accepts data_out when data_valid is high
//   data_out, data_valid    assembled word and its valid flag
//   busy                    frame reception in progress
//   overrun                 sticky: start arrived in HOLD without hand-off
//   parity_err              even-parity check result for the held word
//
// Optional feature macro: SER_TO_PAR8_PARITY_EN (adds a parity bit after the data bits).
module ser_to_par8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ser_in,
  input  logic             bit_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             vld_q;
  logic             busy_q;
  logic             ovr_q;
  logic             last_bit;

  // Shift direction is chosen so that after exactly WIDTH shifts from a cleared
  // register the first received bit sits at bit 0 (LSB-first) or WIDTH-1 (MSB-first).
  always_comb begin
    if (MSB_FIRST) begin
      shreg_d = {shreg_q[WIDTH-2:0], ser_in};
    end else begin
      shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
    end
  end

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef SER_TO_PAR8_PARITY_EN
  logic perr_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SER_TO_PAR8_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        SHIFT: begin
          if (start) begin
            // restart wins over a bit presented on the same cycle
            shreg_q <= '0;
            cnt_q   <= '0;
          end else if (bit_valid) begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_q + CW'(1);
            if (last_bit) begin
`ifdef SER_TO_PAR8_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= HOLD;
              data_q  <= shreg_d;
              vld_q   <= 1'b1;
              busy_q  <= 1'b0;
`endif
            end
          end
        end

        PARITY: begin
`ifdef SER_TO_PAR8_PARITY_EN
          if (start) begin
            state_q <= SHIFT;
            shreg_q <= '0;
            cnt_q   <= '0;
          end else if (bit_valid) begin
            state_q <= HOLD;
            data_q  <= shreg_q;
            vld_q   <= 1'b1;
            busy_q  <= 1'b0;
            // even parity: XOR over data and parity bit must be 0
            perr_q  <= (^shreg_q) ^ ser_in;
          end
`else
          state_q <= IDLE;
`endif
        end

        HOLD: begin
          if (out_ready) begin
            vld_q <= 1'b0;
            if (start) begin
              // hand-off and new frame on the same edge
              state_q <= SHIFT;
              shreg_q <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (start) begin
            ovr_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = vld_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;
`ifdef SER_TO_PAR8_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
